// File: rtl/dmem_responder_if.sv
// Data-memory request/response bus between the core's load/store path
// and the memory-side responder.
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata,
        input  ready, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rdata, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: latches a word request, stalls WAIT
// cycles, then commits/samples the internal RAM and strobes ready once.
module dmem_responder #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus,
    output logic              busy,
    output logic [15:0]       wr_count
);

    localparam int          IW        = $clog2(DEPTH);
    localparam logic [29:0] LIMIT     = 30'(DEPTH);
    localparam logic [3:0]  WAIT_LD   = 4'(WAIT);
    localparam bit          ZERO_WAIT = (WAIT == 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lwe;
    logic [31:0] laddr;
    logic [31:0] lwdata;
    logic [31:0] mem [DEPTH];

    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        cur_bad;
    logic [IW-1:0] cur_idx;
    logic        enter_resp;
    logic        commit;

    // With zero wait states the response is formed from the live request.
    always_comb begin
        cur_we    = lwe;
        cur_addr  = laddr;
        cur_wdata = lwdata;
        if (state == S_IDLE) begin
            cur_we    = bus.we;
            cur_addr  = bus.addr;
            cur_wdata = bus.wdata;
        end
        cur_bad = (cur_addr[1:0] != 2'b00) |
                  (cur_addr[31:2] >= LIMIT);
        cur_idx = cur_addr[IW+1:2];
        enter_resp = 1'b0;
        if (!reset) begin
            if (state == S_IDLE && bus.req && ZERO_WAIT)
                enter_resp = 1'b1;
            if (state == S_WAIT && cnt == 4'd1)
                enter_resp = 1'b1;
        end
        commit = enter_resp && cur_we && !cur_bad;
    end

    always_ff @(posedge clk) begin
        if (commit)
            mem[cur_idx] <= cur_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            lwe       <= 1'b0;
            laddr     <= 32'd0;
            lwdata    <= 32'd0;
            bus.ready <= 1'b0;
            bus.err   <= 1'b0;
            bus.rdata <= 32'd0;
            busy      <= 1'b0;
            wr_count  <= 16'd0;
        end else begin
            bus.ready <= 1'b0;
            bus.err   <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.req) begin
                        lwe    <= bus.we;
                        laddr  <= bus.addr;
                        lwdata <= bus.wdata;
                        cnt    <= WAIT_LD;
                        busy   <= 1'b1;
                        state  <= ZERO_WAIT ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd1)
                        state <= S_RESP;
                    else
                        cnt <= cnt - 4'd1;
                end
                S_RESP: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (enter_resp) begin
                bus.ready <= 1'b1;
                bus.err   <= cur_bad;
                if (cur_bad || cur_we)
                    bus.rdata <= 32'd0;
                else
                    bus.rdata <= mem[cur_idx];
                if (commit)
                    wr_count <= wr_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table on WAIT=2 plus
// back-to-back and reset-mid-access sequences on WAIT=0/2/3 copies.
module tb_dmem_responder;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [15:0] exp_wrc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          sel = 2;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;

    logic        rdy;
    logic [31:0] rd;
    logic        er;
    logic        bsy;
    logic [15:0] wc;

    logic        busy0, busy2, busy3;
    logic [15:0] wrc0, wrc2, wrc3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    vec_t vecs[10];

    dmem_responder_if b0();
    dmem_responder_if b2();
    dmem_responder_if b3();

    assign b0.req   = (sel == 0) && req;
    assign b0.we    = we;
    assign b0.addr  = addr;
    assign b0.wdata = wdata;
    assign b2.req   = (sel == 2) && req;
    assign b2.we    = we;
    assign b2.addr  = addr;
    assign b2.wdata = wdata;
    assign b3.req   = (sel == 3) && req;
    assign b3.we    = we;
    assign b3.addr  = addr;
    assign b3.wdata = wdata;

    dmem_responder #(.DEPTH(64), .WAIT(0)) u0 (
        .clk(clk), .reset(rst), .bus(b0.slave),
        .busy(busy0), .wr_count(wrc0)
    );
    dmem_responder #(.DEPTH(64), .WAIT(2)) u2 (
        .clk(clk), .reset(rst), .bus(b2.slave),
        .busy(busy2), .wr_count(wrc2)
    );
    dmem_responder #(.DEPTH(64), .WAIT(3)) u3 (
        .clk(clk), .reset(rst), .bus(b3.slave),
        .busy(busy3), .wr_count(wrc3)
    );

    always_comb begin
        rdy = b2.ready;
        rd  = b2.rdata;
        er  = b2.err;
        bsy = busy2;
        wc  = wrc2;
        if (sel == 0) begin
            rdy = b0.ready;
            rd  = b0.rdata;
            er  = b0.err;
            bsy = busy0;
            wc  = wrc0;
        end else if (sel == 3) begin
            rdy = b3.ready;
            rd  = b3.rdata;
            er  = b3.err;
            bsy = busy3;
            wc  = wrc3;
        end
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic do_access(input logic w,
                             input logic [31:0] a,
                             input logic [31:0] d,
                             input logic [31:0] erd,
                             input logic ee,
                             input logic [15:0] ewc,
                             input int lat);
        int n;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        check("busy_on_accept", 32'(bsy), 32'd1);
        n = 0;
        while (!rdy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, lat);
        check("rdata", rd, erd);
        check("err", 32'(er), 32'(ee));
        check("wr_count", 32'(wc), 32'(ewc));
        req = 1'b0;
        @(posedge clk); #1;
        check("ready_one_cycle", 32'(rdy), 32'd0);
        check("busy_idle", 32'(bsy), 32'd0);
        check("err_low", 32'(er), 32'd0);
    endtask

    task automatic wait_ready(output int t);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 30);
        t = rdy ? cyc : -1000;
    endtask

    task automatic b2b(input int gap);
        int t1, t2;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h0000_0064;
        wait_ready(t1);
        wait_ready(t2);
        req = 1'b0;
        check("b2b_gap", t2 - t1, gap);
        @(posedge clk); #1;
    endtask

    initial begin
        logic saw;
        vecs[0] = '{1'b1, 32'h64, 32'h7,        32'h0,        1'b0, 16'd1};
        vecs[1] = '{1'b0, 32'h64, 32'h0,        32'h7,        1'b0, 16'd1};
        vecs[2] = '{1'b1, 32'h66, 32'hDEADBEEF, 32'h0,        1'b1, 16'd1};
        vecs[3] = '{1'b0, 32'h64, 32'h0,        32'h7,        1'b0, 16'd1};
        vecs[4] = '{1'b0, 32'h100, 32'h0,       32'h0,        1'b1, 16'd1};
        vecs[5] = '{1'b1, 32'hFC, 32'hA5A55A5A, 32'h0,        1'b0, 16'd2};
        vecs[6] = '{1'b0, 32'hFC, 32'h0,        32'hA5A55A5A, 1'b0, 16'd2};
        vecs[7] = '{1'b0, 32'h62, 32'h0,        32'h0,        1'b1, 16'd2};
        vecs[8] = '{1'b1, 32'hFC, 32'h0BADF00D, 32'h0,        1'b0, 16'd3};
        vecs[9] = '{1'b0, 32'hFC, 32'h0,        32'h0BADF00D, 1'b0, 16'd3};

        // Reset held with a live write request: nothing may be accepted.
        sel = 2;
        req = 1'b1; we = 1'b1; addr = 32'h64; wdata = 32'h99;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst_ready", 32'(rdy), 32'd0);
            check("rst_err", 32'(er), 32'd0);
            check("rst_busy", 32'(bsy), 32'd0);
            check("rst_rdata", rd, 32'd0);
            check("rst_wrc", 32'(wc), 32'd0);
        end
        @(negedge clk);
        req = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata,
                      vecs[i].exp_rdata, vecs[i].exp_err,
                      vecs[i].exp_wrc, 2);

        b2b(4);

        sel = 0;
        do_access(1'b1, 32'h8, 32'h1234_5678, 32'h0, 1'b0, 16'd1, 0);
        do_access(1'b0, 32'h8, 32'h0, 32'h1234_5678, 1'b0, 16'd1, 0);
        b2b(2);

        sel = 3;
        do_access(1'b1, 32'h64, 32'h11, 32'h0, 1'b0, 16'd1, 3);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("wrc_cleared", 32'(wc), 32'd0);

        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h64; wdata = 32'h55;
        @(posedge clk); #1;
        check("mid_accepted", 32'(bsy), 32'd1);
        rst = 1'b1;
        req = 1'b0;
        @(posedge clk); #1;
        check("mid_busy_clr", 32'(bsy), 32'd0);
        @(negedge clk); rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            saw = saw | rdy;
        end
        check("mid_no_ready", 32'(saw), 32'd0);
        check("mid_wrc", 32'(wc), 32'd0);
        do_access(1'b0, 32'h64, 32'h0, 32'h11, 1'b0, 16'd0, 3);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
